// File: rtl/lut_preload_sequencer.sv
// Preload sequencer: streams clause nodes and pointer tables into the lookup latency buffer, inserting
// change-engine pulses and zero pointer tables for unused engines; strobes lag their decision by 1 cycle, ready is state-only.
package lut_preload_pkg;
  typedef struct packed {
    logic [15:0] lit_a;
    logic [15:0] lit_b;
    logic [15:0] lit_c;
  } node_t;

  typedef struct packed {
    logic [15:0] watch_head;
    logic [15:0] watch_len;
  } dummy_entry_t;
endpackage

module lut_preload_sequencer
  import lut_preload_pkg::*;
#(
  parameter int NUM_ENGINE  = 4,
  parameter int LIT_IDX_MAX = 4,
  parameter int CNT_W       = 16,
  localparam int ENG_W      = (NUM_ENGINE > 1) ? $clog2(NUM_ENGINE) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [ENG_W:0]   num_engine,
  input  logic [CNT_W-1:0] num_clause,
  input  node_t            clause_in,
  input  logic             clause_valid_in,
  output logic             clause_ready_out,
  input  dummy_entry_t     ptr_in,
  input  logic             ptr_valid_in,
  output logic             ptr_ready_out,
  output node_t            clause_out,
  output logic             load_clause_out,
  output dummy_entry_t     ptr_out,
  output logic             load_ptr_out,
  output logic             load_change_engine_out,
  output logic             busy,
  output logic             done,
  output logic [ENG_W-1:0] cur_engine
);
  localparam int PTR_N  = 2*LIT_IDX_MAX + 1;
  localparam int PCNT_W = $clog2(PTR_N + 1);
  localparam logic [ENG_W:0]    NUM_ENG_L = (ENG_W+1)'(NUM_ENGINE);
  localparam logic [ENG_W-1:0]  LAST_ENG  = ENG_W'(NUM_ENGINE - 1);
  localparam logic [PCNT_W-1:0] LAST_PTR  = PCNT_W'(PTR_N - 1);

  typedef enum logic [2:0] {IDLE, ALIGN, CLAUSE, PTR, NEXT, DONE} state_t;

  state_t            state_q, state_d;
  logic [ENG_W-1:0]  eng_q, hw_eng_q, next_eng;
  logic [ENG_W:0]    num_eng_q, num_eng_clamped;
  logic [CNT_W-1:0]  num_clause_q, ccnt_q;
  logic [PCNT_W-1:0] pcnt_q;
  logic              real_eng, go_first, go_next;
  logic              last_clause, last_ptr, last_eng;
  logic              clause_hs, ptr_hs, pad, ptr_step, pulse;

  assign num_eng_clamped = (num_engine > NUM_ENG_L) ? NUM_ENG_L : num_engine;
  assign next_eng        = eng_q + ENG_W'(1);
  assign real_eng        = {1'b0, eng_q} < num_eng_q;
  assign go_first        = (num_eng_q != '0) && (num_clause_q != '0);
  assign go_next         = ({1'b0, next_eng} < num_eng_q) && (num_clause_q != '0);
  assign last_clause     = ccnt_q == (num_clause_q - CNT_W'(1));
  assign last_ptr        = pcnt_q == LAST_PTR;
  assign last_eng        = eng_q == LAST_ENG;
  assign clause_hs       = clause_valid_in && clause_ready_out;
  assign ptr_hs          = ptr_valid_in && ptr_ready_out;
  assign ptr_step        = ptr_hs || pad;
  assign cur_engine      = eng_q;

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ALIGN;
      // Wait until the buffer's engine indicator has wrapped back to engine 0.
      ALIGN:   if (hw_eng_q == '0) state_d = go_first ? CLAUSE : PTR;
      CLAUSE:  if (clause_hs && last_clause) state_d = PTR;
      PTR:     if (ptr_step && last_ptr) state_d = last_eng ? DONE : NEXT;
      NEXT:    state_d = go_next ? CLAUSE : PTR;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    clause_ready_out = 1'b0;
    ptr_ready_out    = 1'b0;
    pad              = 1'b0;
    pulse            = 1'b0;
    busy             = state_q != IDLE;
    done             = state_q == DONE;
    case (state_q)
      ALIGN:   pulse = hw_eng_q != '0;
      CLAUSE:  clause_ready_out = 1'b1;
      PTR: begin
        ptr_ready_out = real_eng;
        pad           = !real_eng;
      end
      NEXT:    pulse = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      clause_out             <= '0;
      load_clause_out        <= 1'b0;
      ptr_out                <= '0;
      load_ptr_out           <= 1'b0;
      load_change_engine_out <= 1'b0;
      hw_eng_q               <= '0;
      eng_q                  <= '0;
      num_eng_q              <= '0;
      num_clause_q           <= '0;
      ccnt_q                 <= '0;
      pcnt_q                 <= '0;
    end else begin
      load_clause_out        <= clause_hs;
      clause_out             <= clause_hs ? clause_in : '0;
      load_ptr_out           <= ptr_step;
      ptr_out                <= ptr_hs ? ptr_in : '0;
      load_change_engine_out <= pulse;
      if (pulse) hw_eng_q <= (hw_eng_q == LAST_ENG) ? '0 : hw_eng_q + ENG_W'(1);
      if (state_q == IDLE && start) begin
        num_eng_q    <= num_eng_clamped;
        num_clause_q <= num_clause;
        eng_q        <= '0;
      end
      if (state_q == NEXT) eng_q <= next_eng;
      if (clause_hs) ccnt_q <= last_clause ? '0 : ccnt_q + CNT_W'(1);
      if (ptr_step)  pcnt_q <= last_ptr ? '0 : pcnt_q + PCNT_W'(1);
    end
  end
endmodule

// File: tb/tb_lut_preload_sequencer.sv
// Directed bench for lut_preload_sequencer with NUM_ENGINE=4, LIT_IDX_MAX=4 (9 pointer entries per engine).
module tb_lut_preload_sequencer;
  import lut_preload_pkg::*;

  localparam int NE    = 4;
  localparam int ENG_W = 2;
  localparam byte EV_C = 8'd1;
  localparam byte EV_P = 8'd2;
  localparam byte EV_E = 8'd3;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [ENG_W:0]   num_engine = '0;
  logic [15:0]      num_clause = '0;
  node_t            clause_in = '0;
  logic             clause_valid_in = 1'b0;
  logic             clause_ready_out;
  dummy_entry_t     ptr_in = '0;
  logic             ptr_valid_in = 1'b0;
  logic             ptr_ready_out;
  node_t            clause_out;
  logic             load_clause_out;
  dummy_entry_t     ptr_out;
  logic             load_ptr_out;
  logic             load_change_engine_out;
  logic             busy;
  logic             done;
  logic [ENG_W-1:0] cur_engine;

  int checks = 0;
  int failures = 0;

  node_t        clause_log[$];
  dummy_entry_t ptr_log[$];
  byte          ev_log[$];
  int           n_chg = 0;
  int           n_done = 0;
  int           n_viol = 0;

  lut_preload_sequencer #(.NUM_ENGINE(NE), .LIT_IDX_MAX(4), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .start(start),
    .num_engine(num_engine), .num_clause(num_clause),
    .clause_in(clause_in), .clause_valid_in(clause_valid_in), .clause_ready_out(clause_ready_out),
    .ptr_in(ptr_in), .ptr_valid_in(ptr_valid_in), .ptr_ready_out(ptr_ready_out),
    .clause_out(clause_out), .load_clause_out(load_clause_out),
    .ptr_out(ptr_out), .load_ptr_out(load_ptr_out),
    .load_change_engine_out(load_change_engine_out),
    .busy(busy), .done(done), .cur_engine(cur_engine)
  );

  always #5 clock = ~clock;

  function automatic node_t mk_node(int i);
    node_t n;
    n.lit_a = 16'(i);
    n.lit_b = 16'(i * 7 + 3);
    n.lit_c = 16'hc000 | 16'(i);
    return n;
  endfunction

  function automatic dummy_entry_t mk_ptr(int i);
    dummy_entry_t e;
    e.watch_head = 16'(i + 1);
    e.watch_len  = 16'h8000 | 16'(i);
    return e;
  endfunction

  function automatic int chg_before_load(int base);
    int n = 0;
    for (int i = base; i < ev_log.size(); i++) begin
      if (ev_log[i] != EV_E) break;
      n++;
    end
    return n;
  endfunction

  // Output monitor: logs every strobe and counts protocol violations.
  always @(negedge clock) begin
    if (load_clause_out) begin clause_log.push_back(clause_out); ev_log.push_back(EV_C); end
    if (load_ptr_out) begin ptr_log.push_back(ptr_out); ev_log.push_back(EV_P); end
    if (load_change_engine_out) begin n_chg++; ev_log.push_back(EV_E); end
    if (done) n_done++;
    if ((int'(load_clause_out) + int'(load_ptr_out) + int'(load_change_engine_out)) > 1) n_viol++;
    if (!load_clause_out && clause_out != '0) n_viol++;
    if (!load_ptr_out && ptr_out != '0) n_viol++;
  end

  // Runs one job; k counts cycles after the edge that samples start. Stops at done, at abort_k, or at the budget.
  task automatic drive_run(input int ne, input int nc, input bit toggle_clause, input bit stall_ptr,
                           input bit poke_start, input int abort_k,
                           output int done_k, output int c_hs, output int p_hs, output int dep);
    int c_idx = 0;
    int p_idx = 0;
    logic r0c, r0p;
    done_k = -1; c_hs = 0; p_hs = 0; dep = 0;
    @(negedge clock);
    start = 1'b1; num_engine = 3'(ne); num_clause = 16'(nc);
    clause_valid_in = 1'b0; ptr_valid_in = 1'b0;
    @(negedge clock);
    start = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (k == abort_k) break;
      if (done) begin done_k = k; break; end
      start = poke_start && (k == 20);
      clause_in = mk_node(c_idx);
      ptr_in = mk_ptr(p_idx);
      clause_valid_in = 1'b0; ptr_valid_in = 1'b0;
      #1;
      r0c = clause_ready_out; r0p = ptr_ready_out;
      clause_valid_in = toggle_clause ? k[0] : 1'b1;
      ptr_valid_in = !(stall_ptr && k >= 5 && k < 10);
      #1;
      if (clause_ready_out !== r0c || ptr_ready_out !== r0p) dep++;
      if (clause_valid_in && clause_ready_out) begin c_idx++; c_hs++; end
      if (ptr_valid_in && ptr_ready_out) begin p_idx++; p_hs++; end
      @(negedge clock);
    end
    #2;
    start = 1'b0; clause_valid_in = 1'b0; ptr_valid_in = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; clause_valid_in = 1'b1; ptr_valid_in = 1'b1;
    num_engine = 3'd4; num_clause = 16'd3;
    repeat (3) @(negedge clock);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL reset_busy_done got=%b%b want=00", busy, done); end
    checks++; if ({load_clause_out, load_ptr_out, load_change_engine_out} !== 3'b000) begin failures++; $display("FAIL reset_strobes got=%b want=000", {load_clause_out, load_ptr_out, load_change_engine_out}); end
    checks++; if (clause_out !== '0 || ptr_out !== '0) begin failures++; $display("FAIL reset_data got=%h/%h want=0", clause_out, ptr_out); end
    checks++; if (clause_ready_out !== 1'b0 || ptr_ready_out !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b%b want=00", clause_ready_out, ptr_ready_out); end
    checks++; if (cur_engine !== '0) begin failures++; $display("FAIL reset_cur_engine got=%0d want=0", cur_engine); end
    reset = 1'b0; start = 1'b0; clause_valid_in = 1'b0; ptr_valid_in = 1'b0;
    @(negedge clock);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_release_idle busy=%b want=0", busy); end
  endtask

  task automatic test_full_run();
    int cb = clause_log.size(), pb = ptr_log.size(), eb = ev_log.size();
    int c0 = n_chg, d0 = n_done, v0 = n_viol;
    int done_k, c_hs, p_hs, dep;
    drive_run(4, 3, 1'b0, 1'b0, 1'b0, -1, done_k, c_hs, p_hs, dep);
    checks++; if (done_k !== 52) begin failures++; $display("FAIL full_done_cycle got=%0d want=52", done_k); end
    checks++; if (clause_log.size() - cb !== 12) begin failures++; $display("FAIL full_clause_count got=%0d want=12", clause_log.size() - cb); end
    checks++; if (ptr_log.size() - pb !== 36) begin failures++; $display("FAIL full_ptr_count got=%0d want=36", ptr_log.size() - pb); end
    checks++; if (n_chg - c0 !== 3) begin failures++; $display("FAIL full_change_pulses got=%0d want=3", n_chg - c0); end
    checks++; if (chg_before_load(eb) !== 0) begin failures++; $display("FAIL full_align_pulses got=%0d want=0", chg_before_load(eb)); end
    // Per engine: 3 clauses, 9 pointers, then one change pulse.
    for (int i = 0; i < 51 && eb + i < ev_log.size(); i++) begin
      byte want = ((i % 13) < 3) ? EV_C : (((i % 13) < 12) ? EV_P : EV_E);
      checks++; if (ev_log[eb + i] !== want) begin failures++; $display("FAIL full_event_order[%0d] got=%0d want=%0d", i, ev_log[eb + i], want); end
    end
    for (int i = 0; i < 12; i++) begin
      node_t got = (cb + i < clause_log.size()) ? clause_log[cb + i] : '0;
      checks++; if (got !== mk_node(i)) begin failures++; $display("FAIL full_clause_data[%0d] got=%h want=%h", i, got, mk_node(i)); end
    end
    for (int i = 0; i < 36; i++) begin
      dummy_entry_t got = (pb + i < ptr_log.size()) ? ptr_log[pb + i] : '0;
      checks++; if (got !== mk_ptr(i)) begin failures++; $display("FAIL full_ptr_data[%0d] got=%h want=%h", i, got, mk_ptr(i)); end
    end
    checks++; if (n_done - d0 !== 1) begin failures++; $display("FAIL full_done_pulses got=%0d want=1", n_done - d0); end
    checks++; if (n_viol - v0 !== 0 || dep !== 0) begin failures++; $display("FAIL full_protocol viol=%0d dep=%0d want=0", n_viol - v0, dep); end
    @(negedge clock);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL full_idle_after busy=%b want=0", busy); end
  endtask

  task automatic test_back_to_back();
    int cb = clause_log.size(), pb = ptr_log.size(), eb = ev_log.size();
    int c0 = n_chg, d0 = n_done;
    int done_k, c_hs, p_hs, dep;
    drive_run(4, 3, 1'b0, 1'b0, 1'b1, -1, done_k, c_hs, p_hs, dep);
    checks++; if (chg_before_load(eb) !== 1) begin failures++; $display("FAIL b2b_align_pulses got=%0d want=1", chg_before_load(eb)); end
    checks++; if (done_k !== 53) begin failures++; $display("FAIL b2b_done_cycle got=%0d want=53", done_k); end
    checks++; if (n_chg - c0 !== 4) begin failures++; $display("FAIL b2b_change_pulses got=%0d want=4", n_chg - c0); end
    checks++; if (clause_log.size() - cb !== 12 || ptr_log.size() - pb !== 36) begin failures++; $display("FAIL b2b_counts got=%0d/%0d want=12/36", clause_log.size() - cb, ptr_log.size() - pb); end
    repeat (3) @(negedge clock);
    checks++; if (busy !== 1'b0 || n_done - d0 !== 1) begin failures++; $display("FAIL b2b_start_while_busy busy=%b dones=%0d want=0/1", busy, n_done - d0); end
  endtask

  task automatic test_stall();
    int cb = clause_log.size(), pb = ptr_log.size(), v0 = n_viol;
    int done_k, c_hs, p_hs, dep;
    drive_run(4, 3, 1'b1, 1'b1, 1'b0, -1, done_k, c_hs, p_hs, dep);
    checks++; if (done_k <= 53) begin failures++; $display("FAIL stall_done_cycle got=%0d want>53", done_k); end
    checks++; if (c_hs !== 12 || p_hs !== 36) begin failures++; $display("FAIL stall_handshakes got=%0d/%0d want=12/36", c_hs, p_hs); end
    checks++; if (clause_log.size() - cb !== 12 || ptr_log.size() - pb !== 36) begin failures++; $display("FAIL stall_counts got=%0d/%0d want=12/36", clause_log.size() - cb, ptr_log.size() - pb); end
    for (int i = 0; i < 12; i++) begin
      node_t got = (cb + i < clause_log.size()) ? clause_log[cb + i] : '0;
      checks++; if (got !== mk_node(i)) begin failures++; $display("FAIL stall_clause_data[%0d] got=%h want=%h", i, got, mk_node(i)); end
    end
    for (int i = 0; i < 36; i++) begin
      dummy_entry_t got = (pb + i < ptr_log.size()) ? ptr_log[pb + i] : '0;
      checks++; if (got !== mk_ptr(i)) begin failures++; $display("FAIL stall_ptr_data[%0d] got=%h want=%h", i, got, mk_ptr(i)); end
    end
    checks++; if (dep !== 0) begin failures++; $display("FAIL stall_ready_depends_on_valid got=%0d want=0", dep); end
    checks++; if (n_viol - v0 !== 0) begin failures++; $display("FAIL stall_protocol got=%0d want=0", n_viol - v0); end
  endtask

  task automatic test_padding();
    int cb = clause_log.size(), pb = ptr_log.size();
    int done_k, c_hs, p_hs, dep;
    drive_run(2, 3, 1'b0, 1'b0, 1'b0, -1, done_k, c_hs, p_hs, dep);
    checks++; if (done_k !== 47) begin failures++; $display("FAIL pad_done_cycle got=%0d want=47", done_k); end
    checks++; if (p_hs !== 18) begin failures++; $display("FAIL pad_ptr_handshakes got=%0d want=18", p_hs); end
    checks++; if (clause_log.size() - cb !== 6 || ptr_log.size() - pb !== 36) begin failures++; $display("FAIL pad_counts got=%0d/%0d want=6/36", clause_log.size() - cb, ptr_log.size() - pb); end
    for (int i = 0; i < 36; i++) begin
      dummy_entry_t got = (pb + i < ptr_log.size()) ? ptr_log[pb + i] : mk_ptr(99);
      dummy_entry_t want = (i < 18) ? mk_ptr(i) : '0;
      checks++; if (got !== want) begin failures++; $display("FAIL pad_ptr_data[%0d] got=%h want=%h", i, got, want); end
    end
  endtask

  task automatic test_reset_mid_run();
    int cb, pb, eb, c0;
    int done_k, c_hs, p_hs, dep;
    drive_run(4, 3, 1'b0, 1'b0, 1'b0, 21, done_k, c_hs, p_hs, dep);
    checks++; if (cur_engine !== 2'd1 || load_ptr_out !== 1'b1 || ptr_ready_out !== 1'b1) begin failures++; $display("FAIL midrun_in_ptr eng=%0d load_ptr=%b rdy=%b want=1/1/1", cur_engine, load_ptr_out, ptr_ready_out); end
    reset = 1'b1;
    @(negedge clock);
    checks++; if (busy !== 1'b0 || {load_clause_out, load_ptr_out, load_change_engine_out, done} !== 4'b0) begin failures++; $display("FAIL midrun_reset_outputs busy=%b strobes=%b want=0", busy, {load_clause_out, load_ptr_out, load_change_engine_out, done}); end
    checks++; if (ptr_out !== '0 || cur_engine !== '0 || ptr_ready_out !== 1'b0) begin failures++; $display("FAIL midrun_reset_data ptr=%h eng=%0d rdy=%b want=0", ptr_out, cur_engine, ptr_ready_out); end
    reset = 1'b0;
    cb = clause_log.size(); pb = ptr_log.size(); eb = ev_log.size(); c0 = n_chg;
    drive_run(1, 1, 1'b0, 1'b0, 1'b0, -1, done_k, c_hs, p_hs, dep);
    checks++; if (chg_before_load(eb) !== 0) begin failures++; $display("FAIL fresh_align_pulses got=%0d want=0", chg_before_load(eb)); end
    checks++; if (done_k !== 41) begin failures++; $display("FAIL fresh_done_cycle got=%0d want=41", done_k); end
    checks++; if (n_chg - c0 !== 3 || p_hs !== 9) begin failures++; $display("FAIL fresh_pulses_handshakes got=%0d/%0d want=3/9", n_chg - c0, p_hs); end
    checks++; if (clause_log.size() - cb !== 1 || ptr_log.size() - pb !== 36) begin failures++; $display("FAIL fresh_counts got=%0d/%0d want=1/36", clause_log.size() - cb, ptr_log.size() - pb); end
    checks++; if (clause_log.size() > cb && clause_log[cb] !== mk_node(0)) begin failures++; $display("FAIL fresh_clause_data got=%h want=%h", clause_log[cb], mk_node(0)); end
    for (int i = 0; i < 36; i++) begin
      dummy_entry_t got = (pb + i < ptr_log.size()) ? ptr_log[pb + i] : mk_ptr(99);
      dummy_entry_t want = (i < 9) ? mk_ptr(i) : '0;
      checks++; if (got !== want) begin failures++; $display("FAIL fresh_ptr_data[%0d] got=%h want=%h", i, got, want); end
    end
  endtask

  // num_engine=7 also exercises the clamp to NUM_ENGINE.
  task automatic test_zero_clause();
    int cb = clause_log.size(), pb = ptr_log.size(), eb = ev_log.size(), c0 = n_chg, d0 = n_done;
    int done_k, c_hs, p_hs, dep;
    drive_run(7, 0, 1'b0, 1'b0, 1'b0, -1, done_k, c_hs, p_hs, dep);
    checks++; if (done_k !== 41) begin failures++; $display("FAIL zero_done_cycle got=%0d want=41", done_k); end
    checks++; if (clause_log.size() - cb !== 0 || c_hs !== 0) begin failures++; $display("FAIL zero_no_clause got=%0d/%0d want=0/0", clause_log.size() - cb, c_hs); end
    checks++; if (ptr_log.size() - pb !== 36 || p_hs !== 36) begin failures++; $display("FAIL zero_ptr_count got=%0d/%0d want=36/36", ptr_log.size() - pb, p_hs); end
    checks++; if (n_chg - c0 !== 4 || chg_before_load(eb) !== 1) begin failures++; $display("FAIL zero_pulses got=%0d/%0d want=4/1", n_chg - c0, chg_before_load(eb)); end
    checks++; if (n_done - d0 !== 1) begin failures++; $display("FAIL zero_done_pulses got=%0d want=1", n_done - d0); end
    for (int i = 0; i < 36; i++) begin
      dummy_entry_t got = (pb + i < ptr_log.size()) ? ptr_log[pb + i] : '0;
      checks++; if (got !== mk_ptr(i)) begin failures++; $display("FAIL zero_ptr_data[%0d] got=%h want=%h", i, got, mk_ptr(i)); end
    end
  endtask

  initial begin
    test_reset();
    test_full_run();
    test_back_to_back();
    test_stall();
    test_padding();
    test_reset_mid_run();
    test_zero_clause();
    repeat (2) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lut_preload_sequencer.md
# lut_preload_sequencer

Sequences the preload of preprocessed SAT data into the per-engine clause and pointer latency buffer. It pulls clause nodes and pointer-table entries from two upstream valid/ready streams and drives the buffer's load strobes. It also inserts change-engine pulses and pads unused engines with zero pointer tables. This keeps the buffer's clause and pointer engine indicators aligned. It sits between the host/DMA preprocess queue and the lookup latency buffer.

## Interface
- NUM_ENGINE, `NUM_ENGINE: number of BCP engines; ENG_W = $clog2(NUM_ENGINE)
- LIT_IDX_MAX, `LIT_IDX_MAX: PTR_N = 2*LIT_IDX_MAX+1 pointer entries per engine table
- CNT_W, 16: width of clause counter
- clock  in  1  single clock; all logic on posedge
- reset  in  1  synchronous, active-high
- start  in  1  begin a run; honoured only in IDLE
- num_engine  in  ENG_W+1  engines carrying real data, sampled at start; clamped to NUM_ENGINE
- num_clause  in  CNT_W  clauses per real engine, sampled at start
- clause_in / clause_valid_in / clause_ready_out  in/in/out  node_t/1/1  clause stream
- ptr_in / ptr_valid_in / ptr_ready_out  in/in/out  dummy_entry_t/1/1  pointer-entry stream
- clause_out, load_clause_out  out  node_t, 1  to buffer clause_in/load_clause_in
- ptr_out, load_ptr_out  out  dummy_entry_t, 1  to buffer ptr_in/load_ptr_in
- load_change_engine_out  out  1  to buffer load_change_engine_in
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at end of run
- cur_engine  out  ENG_W  engine being loaded

## Operation
- States: IDLE, ALIGN, CLAUSE, PTR, NEXT, DONE.
- Internal hw_eng mirrors the buffer's clause engine indicator. It resets to 0 and increments mod NUM_ENGINE on each change pulse issued.
- IDLE→ALIGN on start. Latch num_engine (clamped) and num_clause. eng=0.
- ALIGN: if hw_eng != 0, issue one change pulse per cycle. When hw_eng==0, go to CLAUSE if 0<num_engine and num_clause>0; otherwise go to PTR.
- CLAUSE: clause_ready_out=1. Each handshake forwards a clause and increments ccnt. The handshake with ccnt==num_clause-1 clears ccnt and moves to PTR.
- PTR, real engine (eng<num_engine): ptr_ready_out=1. Each handshake forwards an entry.
- PTR, padded engine (eng≥num_engine): ptr_ready_out=0. A zero entry is emitted every cycle without consuming the stream.
- PTR exit: the entry with pcnt==PTR_N-1 clears pcnt. Go to DONE if eng==NUM_ENGINE-1, otherwise go to NEXT.
- NEXT: one change pulse, eng++, then go to CLAUSE/PTR by the same rule as ALIGN.
- DONE: done=1 for one cycle, then go to IDLE. After a run, hw_eng=NUM_ENGINE-1 and the buffer pointer indicator has wrapped to 0.
- start while busy is ignored. Stream data outside CLAUSE/PTR is not accepted (ready=0).

## Timing
- ready outputs are combinational from state and eng only; they do not depend on valid.
- All buffer-side outputs are registered. A load or change strobe appears exactly 1 cycle after the accepting handshake or pulse decision. clause_out/ptr_out carry the accepted data in the same cycle as the strobe.
- Outputs are 0 when their strobe is low. At most one strobe is high per cycle.
- Throughput is one item per cycle under continuous valid. ALIGN and NEXT each cost 1 cycle per pulse. DONE costs 1 cycle.
- Reset values: all outputs 0, state IDLE, hw_eng/eng/ccnt/pcnt 0. Reset mid-run aborts immediately, and the buffer shares the same reset.
- Counter wrap: ccnt compares against num_clause-1 only when num_clause>0. eng never exceeds NUM_ENGINE-1.

## Test plan
- NUM_ENGINE=4, LIT_IDX_MAX=4, num_engine=4, num_clause=3, streams always valid -> per engine 3 load_clause then 9 load_ptr; 3 change pulses; done at cycle 52 after start; data order preserved.
- Same setup with clause_valid_in toggled every other cycle and ptr_valid_in low for 5 cycles -> strobes only on handshakes; no data drop or duplication; ready never depends on valid.
- num_engine=2 -> engines 2 and 3 get 9 zero ptr entries each with ptr_ready_out=0 and no clause strobes; exactly 18 ptr handshakes total.
- Back-to-back runs -> the second run issues exactly one ALIGN change pulse before its first clause; start asserted while busy is ignored.
- num_clause=0, num_engine=4 -> no load_clause; 36 load_ptr and 3 change pulses; done.
- reset asserted mid-PTR of engine 1 -> next cycle all outputs 0 and busy=0; a fresh run with num_engine=1, num_clause=1 starts with no ALIGN pulse.
